// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS31 state enum, taps and 8-bit step function (x^31 + x^28 + 1).
// Reused by the upstream generator bench, so keep prbs31_next8 self-contained.
package prbs_pkg;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam int TAP_A = 31;
    localparam int TAP_B = 28;

    typedef struct packed {
        logic [30:0] hist;
        logic [7:0]  data;
    } step8_t;

    // hist[0] is the newest bit; data[7] is the first bit produced in time
    function automatic step8_t prbs31_next8(input logic [30:0] hist);
        step8_t r;
        logic b;
        r.hist = hist;
        r.data = '0;
        for (int i = 7; i >= 0; i--) begin
            b = r.hist[TAP_A-1] ^ r.hist[TAP_B-1];
            r.hist = {r.hist[29:0], b};
            r.data[i] = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs31_step8.sv
// prbs31_step8: combinational 8-step advance of the PRBS31 history register.
module prbs31_step8 import prbs_pkg::*; (
    input  logic [30:0] i_hist,
    output logic [7:0]  o_pred,
    output logic [30:0] o_next_hist
);

    step8_t w_step;

    assign w_step      = prbs31_next8(i_hist);
    assign o_pred      = w_step.data;
    assign o_next_hist = w_step.hist;

endmodule

// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising byte-wide PRBS31 checker with lock FSM and saturating error counter.
// Define PRBS31_CHECKER_BIT_ERR_EN to count errored bits instead of errored beats.
module prbs31_checker import prbs_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  clr_cnt,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    state_t          r_state;
    logic [30:0]     r_hist;
    logic [2:0]      r_fill;
    logic [GW-1:0]   r_good;
    logic [BW-1:0]   r_bad;
    logic            r_locked;
    logic            r_err_pulse;
    logic [CNT_W-1:0] r_err_cnt;

    logic [DATA_WIDTH-1:0] w_pred;
    logic [30:0]           w_next_hist;
    logic [30:0]           w_shift;
    logic [DATA_WIDTH-1:0] w_diff;
    logic                  w_mism;
    logic                  w_err;
    logic [CNT_W-1:0]      w_add;
    logic [CNT_W:0]        w_sum;
    logic [CNT_W-1:0]      w_cnt_next;

    prbs31_step8 u_step (
        .i_hist      (r_hist),
        .o_pred      (w_pred),
        .o_next_hist (w_next_hist)
    );

    assign w_shift = {r_hist[22:0], in_data};
    assign w_diff  = in_data ^ w_pred;
    assign w_mism  = |w_diff;
    assign w_err   = in_valid && (r_state == LOCKED) && w_mism;

`ifdef PRBS31_CHECKER_BIT_ERR_EN
    assign w_add = CNT_W'($countones(w_diff));
`else
    assign w_add = CNT_W'(1);
`endif

    // one spare carry bit is enough: the increment never exceeds 8
    assign w_sum      = {1'b0, r_err_cnt} + {1'b0, w_add};
    assign w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_hist      <= '0;
            r_fill      <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (clr_cnt)
                r_err_cnt <= '0;
            else if (w_err)
                r_err_cnt <= w_cnt_next;
            if (in_valid) begin
                case (r_state)
                    HUNT: begin
                        r_hist <= w_shift;
                        r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
                        // an all-zero window never arms CHECK (stuck-at-0 line)
                        if (r_fill >= 3'd3 && w_shift != '0)
                            r_state <= CHECK;
                    end
                    CHECK: begin
                        r_hist <= w_shift;
                        if (w_mism) begin
                            r_state <= HUNT;
                            r_fill  <= '0;
                            r_good  <= '0;
                        end else if (r_good == GW'(LOCK_CNT - 1)) begin
                            r_state  <= LOCKED;
                            r_good   <= '0;
                            r_bad    <= '0;
                            r_locked <= 1'b1;
                        end else begin
                            r_good <= r_good + GW'(1);
                        end
                    end
                    LOCKED: begin
                        // reference free-runs so isolated errors do not corrupt alignment
                        r_hist <= w_next_hist;
                        if (!w_mism) begin
                            r_bad <= '0;
                        end else if (r_bad == BW'(UNLOCK_CNT - 1)) begin
                            r_state  <= HUNT;
                            r_fill   <= '0;
                            r_good   <= '0;
                            r_bad    <= '0;
                            r_locked <= 1'b0;
                        end else begin
                            r_bad <= r_bad + BW'(1);
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;

endmodule
